// File: rtl/dspace_rx_deframer.sv
// Receive-side deframer for the 4-bit dSPACE nibble link: recovers symbol timing
// from the frame-rate square wave, samples nibbles mid-symbol and publishes A/B/C words.
module dspace_rx_deframer #(
  parameter logic [3:0] SYNC_W      = 4'b0000,
  parameter logic [3:0] SYNC_F      = 4'b1111,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       frate_in,
  input  logic [3:0] dspace_in,
  output logic [7:0] Vra,
  output logic [7:0] Vrb,
  output logic [7:0] Vrc,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_lost
);

  typedef enum logic [3:0] {
    S_IDLE, S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_T0, S_T1
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [10:0] r_sym_period;
  logic [10:0] w_sw_period;
  logic [11:0] r_phase;
  logic [11:0] w_phase_max;
  logic [11:0] w_half;
  logic [SYNC_STAGES-1:0] r_frate_sync;
  logic [3:0]  r_din_sync [SYNC_STAGES];
  logic        r_frate_prev;
  logic [23:0] r_shadow;
  logic        w_frate_s;
  logic [3:0]  w_din_s;
  logic        w_rise;
  logic        w_timeout;
  logic        w_strobe;
  logic        w_period_chg;
  logic        w_shift;
  logic        w_commit;
  logic        w_err;

  always_comb begin
    w_sw_period = 11'd750;
    case (sw)
      2'd0:    w_sw_period = 11'd500;
      2'd1:    w_sw_period = 11'd750;
      2'd2:    w_sw_period = 11'd1000;
      default: w_sw_period = 11'd1250;
    endcase
  end

  assign w_frate_s    = r_frate_sync[SYNC_STAGES-1];
  assign w_din_s      = r_din_sync[SYNC_STAGES-1];
  assign w_rise       = w_frate_s & ~r_frate_prev;
  assign w_phase_max  = {r_sym_period, 1'b0};
  assign w_half       = {2'b00, r_sym_period[10:1]};
  // >= rather than == so a shrinking period cannot leave phase stranded above the limit.
  assign w_timeout    = (r_phase >= w_phase_max);
  assign w_strobe     = ~w_rise & ~w_timeout & ~link_lost & (r_phase == w_half);
  assign w_period_chg = (w_sw_period != r_sym_period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_period <= 11'd750;
      r_frate_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_din_sync[i] <= 4'd0;
      r_frate_prev <= 1'b0;
      r_phase      <= 12'd0;
      link_lost    <= 1'b0;
    end else begin
      r_sym_period    <= w_sw_period;
      r_frate_sync[0] <= frate_in;
      r_din_sync[0]   <= dspace_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_frate_sync[i] <= r_frate_sync[i-1];
        r_din_sync[i]   <= r_din_sync[i-1];
      end
      r_frate_prev <= w_frate_s;
      if (w_rise)                   r_phase <= 12'd0;
      else if (r_phase < w_phase_max) r_phase <= r_phase + 12'd1;
      if (w_rise)         link_lost <= 1'b0;
      else if (w_timeout) link_lost <= 1'b1;
    end
  end

  // Data states shift nibbles in order, so after D5 the shadow holds {A, B, C}.
  always_comb begin
    w_next   = r_state;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    w_err    = 1'b0;
    if (w_period_chg || w_timeout) begin
      w_next = S_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE: if (w_din_s == SYNC_W) w_next = S_D0;
        S_D0, S_D1, S_D2, S_D3, S_D4, S_D5: begin
          w_shift = 1'b1;
          w_next  = state_t'(r_state + 4'd1);
        end
        S_T0: begin
          if (w_din_s == SYNC_F) begin
            w_next = S_T1;
          end else begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end
        end
        S_T1: begin
          w_next = S_IDLE;
          if (w_din_s == SYNC_F) w_commit = 1'b1;
          else                   w_err    = 1'b1;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shadow    <= 24'd0;
      Vra         <= 8'd0;
      Vrb         <= 8'd0;
      Vrc         <= 8'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      frame_valid <= w_commit;
      frame_err   <= w_err;
      if (w_shift)  r_shadow <= {r_shadow[19:0], w_din_s};
      if (w_commit) {Vra, Vrb, Vrc} <= r_shadow;
    end
  end

endmodule

// File: tb/tb_dspace_rx_deframer.sv
// Bench for dspace_rx_deframer: directed nibble frames, expected events queued by the
// driver and consumed by an independent monitor.
module tb_dspace_rx_deframer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic       frate_in;
  logic [3:0] dspace_in;
  logic [7:0] Vra, Vrb, Vrc;
  logic       frame_valid, frame_err, link_lost;

  int total = 0;
  int bad   = 0;
  int hold_prints = 0;
  // bit 24 set = frame_err expected, else frame_valid with {Vra,Vrb,Vrc} in [23:0]
  logic [24:0] exp_q[$];
  logic [23:0] mdl = 24'd0;

  localparam logic [35:0] F_A5   = 36'h0A53CF0FF;
  localparam logic [35:0] F_BADT = 36'h0123456FE;
  localparam logic [35:0] F_ZERO = 36'h0000000FF;
  localparam logic [35:0] F_ONES = 36'h0FFFFFFFF;
  localparam logic [35:0] F_INC  = 36'h0123456FF;
  localparam logic [35:0] F_DESC = 36'h0987654FF;
  localparam logic [35:0] F_LAST = 36'h07EC318FF;

  dspace_rx_deframer dut (
    .clk(clk), .rst(rst), .sw(sw), .frate_in(frate_in), .dspace_in(dspace_in),
    .Vra(Vra), .Vrb(Vrb), .Vrc(Vrc),
    .frame_valid(frame_valid), .frame_err(frame_err), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_sym(input logic [3:0] n, input int per);
    dspace_in = n;
    frate_in  = 1'b1;
    repeat (per / 2) @(negedge clk);
    frate_in = 1'b0;
    repeat (per - per / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [35:0] f, input int first, input int last, input int per);
    for (int i = first; i <= last; i++) send_sym(f[35-4*i -: 4], per);
  endtask

  task automatic push_valid(input logic [23:0] v);
    exp_q.push_back({1'b0, v});
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, 24'd0});
  endtask

  // Monitor: consumes expected events and tracks what the outputs must hold.
  always @(negedge clk) begin
    logic [24:0] e;
    if (rst) begin
      mdl = 24'd0;
    end else begin
      if (frame_valid || frame_err) begin
        check("valid_err_exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got valid=%0b err=%0b expected none", frame_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_err", {31'd0, frame_err}, {31'd0, e[24]});
          if (!e[24]) mdl = e[23:0];
        end
      end
      total++;
      if ({Vra, Vrb, Vrc} !== mdl) begin
        bad++;
        if (hold_prints < 20) begin
          hold_prints++;
          $display("FAIL outputs: got %h expected %h", {Vra, Vrb, Vrc}, mdl);
        end
      end
    end
  end

  initial begin
    #900000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1; sw = 2'd1; frate_in = 1'b0; dspace_in = 4'h5;
    repeat (3) @(negedge clk);
    check("reset_outputs", {8'd0, Vra, Vrb, Vrc}, 32'd0);
    check("reset_flags", {29'd0, frame_valid, frame_err, link_lost}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ideal frame at 750-clk symbols
    push_valid(24'hA53CF0);
    send_frame(F_A5, 0, 8, 750);

    // 500-clk symbols: bad trailer, then marker-valued data frames
    sw = 2'd0;
    push_err();
    send_frame(F_BADT, 0, 8, 500);
    check("keep_after_err", {8'd0, Vra, Vrb, Vrc}, 32'h00A53CF0);
    push_valid(24'h000000);
    send_frame(F_ZERO, 0, 8, 500);
    push_valid(24'hFFFFFF);
    send_frame(F_ONES, 0, 8, 500);

    // join mid-frame at the 4th nibble, 1000-clk symbols
    sw = 2'd2;
    send_frame(F_INC, 3, 8, 1000);
    push_valid(24'h123456);
    send_frame(F_INC, 0, 8, 1000);

    // timeout: partial frame, frate held low, remainder must not complete it
    sw = 2'd3;
    send_frame(F_DESC, 0, 1, 1250);
    check("link_ok_before", {31'd0, link_lost}, 32'd0);
    dspace_in = 4'h8;
    frate_in  = 1'b1;
    repeat (625) @(negedge clk);
    frate_in = 1'b0;
    repeat (3000) @(negedge clk);
    check("link_lost_set", {31'd0, link_lost}, 32'd1);
    send_frame(F_DESC, 6, 6, 1250);
    check("link_lost_clear", {31'd0, link_lost}, 32'd0);
    send_frame(F_DESC, 7, 8, 1250);
    push_valid(24'h987654);
    send_frame(F_DESC, 0, 8, 1250);

    // asynchronous reset in the middle of a frame
    sw = 2'd1;
    send_frame(F_INC, 0, 3, 750);
    dspace_in = 4'h4;
    frate_in  = 1'b1;
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {8'd0, Vra, Vrb, Vrc}, 32'd0);
    check("async_reset_flags", {29'd0, frame_valid, frame_err, link_lost}, 32'd0);
    frate_in  = 1'b0;
    dspace_in = 4'h5;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // period change during D2 aborts silently; next frame at 1000-clk symbols
    send_frame(F_INC, 0, 2, 750);
    dspace_in = 4'h3;
    frate_in  = 1'b1;
    repeat (100) @(negedge clk);
    sw = 2'd2;
    repeat (275) @(negedge clk);
    frate_in = 1'b0;
    repeat (375) @(negedge clk);
    send_frame(F_INC, 4, 8, 750);
    push_valid(24'h7EC318);
    send_frame(F_LAST, 0, 8, 1000);

    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
